// File: rtl/hex_display_mux.sv
// hex_display_mux: picks one of NUM_CH packed hex words (manual, step, auto-rotate or hold)
// and drives DIGITS active-low seven-segment displays through a two-stage registered pipeline.
module hex_display_mux #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DIGITS     = 6,
  parameter int unsigned ROT_CYCLES = 50_000_000,
  localparam int unsigned CH_W      = $clog2(NUM_CH)
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic [NUM_CH*DIGITS*4-1:0] values,
  input  logic [1:0]                 mode,
  input  logic [CH_W-1:0]            ch_sel,
  input  logic                       step,
  input  logic                       blank_lz,
  output logic [DIGITS*7-1:0]        segments,
  output logic [CH_W-1:0]            cur_ch
);

  localparam int unsigned ROT_W = $clog2(ROT_CYCLES);
  localparam int unsigned VAL_W = DIGITS * 4;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROT_CYCLES - 1);

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_STEP   = 2'b01;
  localparam logic [1:0] MODE_AUTO   = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  logic [CH_W-1:0]    r_cur_ch;
  logic [VAL_W-1:0]   r_shown;
  logic               r_shown_vld;
  logic               r_step_q;
  logic [ROT_W-1:0]   r_rot_cnt;
  logic [DIGITS*7-1:0] r_seg;

  logic [CH_W-1:0]     w_next_ch;
  logic [CH_W-1:0]     w_cur_ch_nxt;
  logic [ROT_W-1:0]    w_rot_nxt;
  logic [VAL_W-1:0]    w_sel_val;
  logic [DIGITS*7-1:0] w_seg_d;
  logic                w_lz_run;

  function automatic logic [6:0] f_hex7(input logic [3:0] i_nib);
    logic [6:0] w_code;
    case (i_nib)
      4'h0:    w_code = 7'h40;
      4'h1:    w_code = 7'h79;
      4'h2:    w_code = 7'h24;
      4'h3:    w_code = 7'h30;
      4'h4:    w_code = 7'h19;
      4'h5:    w_code = 7'h12;
      4'h6:    w_code = 7'h02;
      4'h7:    w_code = 7'h78;
      4'h8:    w_code = 7'h00;
      4'h9:    w_code = 7'h10;
      4'hA:    w_code = 7'h08;
      4'hB:    w_code = 7'h03;
      4'hC:    w_code = 7'h46;
      4'hD:    w_code = 7'h21;
      4'hE:    w_code = 7'h06;
      default: w_code = 7'h0E;
    endcase
    return w_code;
  endfunction

  always_comb begin
    w_sel_val = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (r_cur_ch == CH_W'(c)) w_sel_val = values[c*VAL_W +: VAL_W];
    end
  end

  // rot_cnt stays at zero outside auto-rotate so every entry starts a full period.
  always_comb begin
    w_next_ch    = (r_cur_ch == LAST_CH) ? '0 : r_cur_ch + CH_W'(1);
    w_cur_ch_nxt = r_cur_ch;
    w_rot_nxt    = '0;
    case (mode)
      MODE_MANUAL: begin
        if (32'(ch_sel) < NUM_CH) w_cur_ch_nxt = ch_sel;
      end
      MODE_STEP: begin
        if (step && !r_step_q) w_cur_ch_nxt = w_next_ch;
      end
      MODE_AUTO: begin
        if (r_rot_cnt == ROT_LAST) w_cur_ch_nxt = w_next_ch;
        else                       w_rot_nxt    = r_rot_cnt + ROT_W'(1);
      end
      default: ;
    endcase
  end

  // Scan from the top digit down; the run of blanks ends at the first non-zero nibble.
  always_comb begin
    w_lz_run = blank_lz;
    w_seg_d  = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      if (r_shown[d*4 +: 4] != 4'h0) w_lz_run = 1'b0;
      if (w_lz_run && d != 0) w_seg_d[d*7 +: 7] = 7'h7F;
      else                    w_seg_d[d*7 +: 7] = f_hex7(r_shown[d*4 +: 4]);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_cur_ch    <= '0;
      r_shown     <= '0;
      r_shown_vld <= 1'b0;
      r_step_q    <= 1'b0;
      r_rot_cnt   <= '0;
      r_seg       <= '1;
    end else begin
      r_step_q  <= step;
      r_rot_cnt <= w_rot_nxt;
      if (mode != MODE_HOLD) begin
        r_cur_ch    <= w_cur_ch_nxt;
        r_shown     <= w_sel_val;
        r_shown_vld <= 1'b1;
        // Displays stay dark until the first real value has reached the shown stage.
        r_seg       <= r_shown_vld ? w_seg_d : '1;
      end
    end
  end

  assign segments = r_seg;
  assign cur_ch   = r_cur_ch;

endmodule

// File: tb/tb_hex_display_mux.sv
// Scoreboard bench for hex_display_mux: stimulus queues expected outputs with a due cycle,
// a negedge monitor compares them against the DUT when they fall due.
module tb_hex_display_mux;

  localparam int unsigned NUM_CH     = 3;
  localparam int unsigned DIGITS     = 6;
  localparam int unsigned ROT_CYCLES = 4;

  localparam logic [6:0] BL = 7'h7F;
  localparam logic [6:0] S0 = 7'h40;
  localparam logic [6:0] S1 = 7'h79;
  localparam logic [6:0] S2 = 7'h24;
  localparam logic [6:0] S3 = 7'h30;
  localparam logic [6:0] S8 = 7'h00;
  localparam logic [6:0] SF = 7'h0E;

  logic        clk = 1'b0;
  logic        reset;
  logic [71:0] values;
  logic [1:0]  mode;
  logic [1:0]  ch_sel;
  logic        step;
  logic        blank_lz;
  logic [41:0] segments;
  logic [1:0]  cur_ch;

  always #5 clk = ~clk;

  hex_display_mux #(
    .NUM_CH    (NUM_CH),
    .DIGITS    (DIGITS),
    .ROT_CYCLES(ROT_CYCLES)
  ) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .values  (values),
    .mode    (mode),
    .ch_sel  (ch_sel),
    .step    (step),
    .blank_lz(blank_lz),
    .segments(segments),
    .cur_ch  (cur_ch)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          sb_due[$];
  bit          sb_is_ch[$];
  logic [41:0] sb_val[$];
  string       sb_name[$];

  int n_total = 0;
  int n_pass  = 0;

  task automatic exp_seg(input string name, input logic [41:0] v, input int k);
    sb_due.push_back(cyc + k);
    sb_is_ch.push_back(1'b0);
    sb_val.push_back(v);
    sb_name.push_back(name);
  endtask

  task automatic exp_ch(input string name, input logic [1:0] c, input int k);
    sb_due.push_back(cyc + k);
    sb_is_ch.push_back(1'b1);
    sb_val.push_back({40'h0, c});
    sb_name.push_back(name);
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [41:0] seg6(input logic [6:0] d5, input logic [6:0] d4,
                                       input logic [6:0] d3, input logic [6:0] d2,
                                       input logic [6:0] d1, input logic [6:0] d0);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  always @(negedge clk) begin
    for (int i = sb_due.size() - 1; i >= 0; i--) begin
      if (sb_due[i] <= cyc) begin
        n_total++;
        if (sb_is_ch[i]) begin
          if (cur_ch === sb_val[i][1:0]) n_pass++;
          else $display("FAIL %s (cycle %0d): cur_ch=%0d expected %0d",
                        sb_name[i], cyc, cur_ch, sb_val[i][1:0]);
        end else begin
          if (segments === sb_val[i]) n_pass++;
          else $display("FAIL %s (cycle %0d): segments=%h expected %h",
                        sb_name[i], cyc, segments, sb_val[i]);
        end
        sb_due.delete(i);
        sb_is_ch.delete(i);
        sb_val.delete(i);
        sb_name.delete(i);
      end
    end
  end

  logic [41:0] seg_ch0, seg_ch1, seg_ch2, seg_zero;

  initial begin
    seg_ch0  = seg6(BL, BL, BL, S1, S2, S3);
    seg_ch1  = seg6(S1, S0, S0, S0, S0, S8);
    seg_ch2  = seg6(BL, BL, BL, BL, S3, S2);
    seg_zero = seg6(BL, BL, BL, BL, BL, S0);

    reset    = 1'b1;
    mode     = 2'b00;
    ch_sel   = 2'd0;
    step     = 1'b0;
    blank_lz = 1'b1;
    values   = {24'h000032, 24'h100008, 24'h000123};

    // Reset held two clocks, displays dark until two clocks after release
    clk_n(1);
    exp_ch("rst_cur_ch", 2'd0, 0);
    exp_seg("rst_blank", '1, 0);
    clk_n(1);
    reset = 1'b0;
    exp_seg("post_rst_blank", '1, 1);
    exp_seg("post_rst_ch0", seg_ch0, 2);
    clk_n(2);

    // Leading-zero blanking on and off
    blank_lz = 1'b0;
    exp_seg("lz_off", seg6(S0, S0, S0, S1, S2, S3), 1);
    clk_n(1);
    blank_lz = 1'b1;
    exp_seg("lz_on", seg_ch0, 1);
    clk_n(1);

    // Value change with fixed channel: two-clock latency, zero shows a single digit
    values[23:0] = 24'h000000;
    exp_seg("val_chg_old", seg_ch0, 1);
    exp_seg("val_zero", seg_zero, 2);
    clk_n(2);

    // Manual select, out-of-range request ignored
    ch_sel = 2'd1;
    exp_ch("man_ch1", 2'd1, 1);
    exp_seg("man_seg1", seg_ch1, 3);
    clk_n(3);
    ch_sel = 2'd3;
    exp_ch("oor_hold_a", 2'd1, 1);
    exp_ch("oor_hold_b", 2'd1, 2);
    clk_n(2);
    ch_sel = 2'd2;
    exp_ch("man_ch2", 2'd2, 1);
    exp_seg("man_seg2_lag", seg_ch1, 2);
    exp_seg("man_seg2", seg_ch2, 3);
    clk_n(3);

    // Step mode: one advance per press regardless of hold length
    ch_sel = 2'd0;
    clk_n(1);
    exp_ch("step_start", 2'd0, 0);
    mode = 2'b01;
    for (int p = 0; p < 3; p++) begin
      logic [1:0] e;
      e = (p == 2) ? 2'd0 : 2'(p + 1);
      step = 1'b1;
      exp_ch("step_adv", e, 1);
      exp_ch("step_held", e, 10);
      clk_n(10);
      step = 1'b0;
      clk_n(3);
    end

    // Auto-rotate every ROT_CYCLES clocks
    mode = 2'b10;
    exp_ch("rot_pre", 2'd0, 3);
    exp_ch("rot_1", 2'd1, 4);
    exp_seg("rot_seg1", seg_ch1, 6);
    exp_ch("rot_2", 2'd2, 8);
    exp_ch("rot_0", 2'd0, 12);
    exp_ch("rot_1b", 2'd1, 16);
    clk_n(18);
    mode = 2'b01;
    clk_n(3);
    mode = 2'b10;
    exp_ch("rot_reenter_pre", 2'd1, 3);
    exp_ch("rot_reenter_adv", 2'd2, 4);
    clk_n(4);

    // Hold freezes channel and display while inputs change
    mode   = 2'b00;
    ch_sel = 2'd1;
    clk_n(4);
    mode   = 2'b11;
    values[47:24] = 24'hFFFFFF;
    ch_sel = 2'd0;
    exp_seg("hold_seg_a", seg_ch1, 1);
    exp_ch("hold_ch", 2'd1, 2);
    exp_seg("hold_seg_b", seg_ch1, 4);
    clk_n(4);
    mode   = 2'b00;
    ch_sel = 2'd1;
    exp_ch("unhold_ch", 2'd1, 1);
    exp_seg("unhold_lag", seg_ch1, 1);
    exp_seg("unhold_all_f", {6{SF}}, 2);
    clk_n(2);

    // Reset mid-rotation clears channel and rotation count
    mode = 2'b10;
    clk_n(2);
    reset = 1'b1;
    exp_ch("rot_rst_ch", 2'd0, 1);
    exp_seg("rot_rst_blank", '1, 1);
    clk_n(1);
    reset = 1'b0;
    exp_seg("rot_rst_dark", '1, 1);
    exp_seg("rot_rst_zero", seg_zero, 2);
    exp_ch("rot_rst_pre", 2'd0, 3);
    exp_ch("rot_rst_adv", 2'd1, 4);
    clk_n(6);

    for (int i = 0; i < 50 && sb_due.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb_due.size() > 0) begin
      $display("FAIL drain: %0d expectations never checked", sb_due.size());
      n_total += sb_due.size();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
